aes_inv_cipher: RTL and testbench

AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/inv_shift_rows.sv | 15 +
 rtl/aes_inv_cipher.sv | 130 +++++++++++++
 tb/tb_aes_inv_cipher.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse cipher: state layout, inverse S-box,
// GF(2^8) arithmetic and round count.
package aes_pkg;

  localparam int NR = 10;

  // Byte [row][col]; FIPS-197 byte i lives at [i%4][i/4].
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b it reduces to a small XOR tree.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_shift_rows.sv
// Combinational InvShiftRows: row r rotates right by r byte positions.
module inv_shift_rows
  import aes_pkg::*;
(
  input  state_t i_state,
  output state_t o_state
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign o_state[r][c] = i_state[r][(c - r + 4) % 4];
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per cycle with an external round-key port.
// Define AES_INV_SBOX_REG_EN to register InvSubBytes(InvShiftRows) and split each round over two cycles.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in_state,
  output logic [3:0] rk_idx,
  input  state_t     rk,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     out_state
);

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][c] = INV_SBOX[s[r][c]];
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) begin
      o[0][c] = gmul(s[0][c], 8'h0e) ^ gmul(s[1][c], 8'h0b) ^ gmul(s[2][c], 8'h0d) ^ gmul(s[3][c], 8'h09);
      o[1][c] = gmul(s[0][c], 8'h09) ^ gmul(s[1][c], 8'h0e) ^ gmul(s[2][c], 8'h0b) ^ gmul(s[3][c], 8'h0d);
      o[2][c] = gmul(s[0][c], 8'h0d) ^ gmul(s[1][c], 8'h09) ^ gmul(s[2][c], 8'h0e) ^ gmul(s[3][c], 8'h0b);
      o[3][c] = gmul(s[0][c], 8'h0b) ^ gmul(s[1][c], 8'h0d) ^ gmul(s[2][c], 8'h09) ^ gmul(s[3][c], 8'h0e);
    end
    return o;
  endfunction

  fsm_t       r_fsm;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [3:0] r_rk_idx;

  state_t w_sr;
  state_t w_sb;
  state_t w_ark;
  state_t w_mc;
  state_t w_next;
  logic   w_round_end;

  inv_shift_rows u_inv_shift_rows (
    .i_state (r_state),
    .o_state (w_sr)
  );

  assign w_sb = inv_sub_bytes(w_sr);

`ifdef AES_INV_SBOX_REG_EN
  state_t r_sb;
  logic   r_phase;
  // Phase 0 captures the S-box result; phase 1 applies key and mixing.
  assign w_ark       = r_sb ^ rk;
  assign w_round_end = r_phase;
`else
  assign w_ark       = w_sb ^ rk;
  assign w_round_end = 1'b1;
`endif

  assign w_mc   = inv_mix_columns(w_ark);
  assign w_next = (r_cnt == 4'd0) ? w_ark : w_mc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rk_idx    <= 4'(NR);
`ifdef AES_INV_SBOX_REG_EN
      r_sb        <= '0;
      r_phase     <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= in_state ^ rk;
            r_cnt      <= 4'(NR - 1);
            r_rk_idx   <= 4'(NR - 1);
            r_in_ready <= 1'b0;
            r_fsm      <= S_ROUND;
          end
        end
        S_ROUND: begin
`ifdef AES_INV_SBOX_REG_EN
          r_phase <= ~r_phase;
          if (!r_phase) r_sb <= w_sb;
`endif
          if (w_round_end) begin
            r_state <= w_next;
            if (r_cnt == 4'd0) begin
              r_fsm       <= S_DONE;
              r_out_valid <= 1'b1;
              r_rk_idx    <= 4'(NR);
            end else begin
              r_cnt    <= r_cnt - 4'd1;
              r_rk_idx <= r_cnt - 4'd1;
            end
          end
        end
        S_DONE: begin
          // No bypass: in_ready rises only after the transfer edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign rk_idx    = r_rk_idx;
  assign out_state = r_state;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: known-answer table, handshake corner cases,
// and randomized blocks checked against a forward-cipher reference model.
module tb_aes_inv_cipher;
  import aes_pkg::state_t;

`ifdef AES_INV_SBOX_REG_EN
  localparam int RKREP = 2;
`else
  localparam int RKREP = 1;
`endif
  localparam int LAT = 1 + 10 * RKREP;
  localparam int NRAND = 1000;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  state_t     in_state;
  logic [3:0] rk_idx;
  state_t     rk;
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox  [256];
  logic [127:0] rkeys [16];
  logic [127:0] exp_q [$];

  aes_inv_cipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic state_t to_state(input logic [127:0] v);
    state_t s;
    for (int i = 0; i < 16; i++) s[i % 4][i / 4] = v[127 - 8 * i -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = s[i % 4][i / 4];
    return v;
  endfunction

  assign rk = to_state(rkeys[rk_idx]);

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int j = 0; j < 11; j++) rkeys[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    for (int j = 11; j < 16; j++) rkeys[j] = '0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ rkeys[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[127 - 8 * i -: 8] = sbox[s[127 - 8 * i -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127 - 8 * (4 * c) -: 8];
          a1 = t[127 - 8 * (4 * c + 1) -: 8];
          a2 = t[127 - 8 * (4 * c + 2) -: 8];
          a3 = t[127 - 8 * (4 * c + 3) -: 8];
          s[127 - 8 * (4 * c)     -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[127 - 8 * (4 * c + 1) -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[127 - 8 * (4 * c + 2) -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[127 - 8 * (4 * c + 3) -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end else begin
        s = t;
      end
      s = s ^ rkeys[rnd];
    end
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string nm);
    logic [255:0] gs;
    logic [255:0] es;
    int e;
    gs = '0;
    es = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = to_state(ct);
    check({nm, "_rdy"}, 256'(in_ready), 256'(1));
    gs = {gs[251:0], rk_idx};
    @(negedge clk);
    in_valid = 1'b0;
    in_state = to_state(~ct);
    e = 1;
    while (!out_valid && e < 60) begin
      gs = {gs[251:0], rk_idx};
      @(negedge clk);
      e++;
    end
    gs = {gs[251:0], rk_idx};
    es = {es[251:0], 4'd10};
    for (int r = 9; r >= 0; r--)
      for (int k = 0; k < RKREP; k++) es = {es[251:0], 4'(r)};
    es = {es[251:0], 4'd10};
    check({nm, "_lat"}, 256'(e), 256'(LAT));
    check({nm, "_pt"}, 256'(from_state(out_state)), 256'(pt));
    check({nm, "_rkseq"}, gs, es);
    check({nm, "_done_rdy"}, 256'(in_ready), 256'(0));
    @(negedge clk);
    check({nm, "_post_vld"}, 256'(out_valid), 256'(0));
    check({nm, "_post_rdy"}, 256'(in_ready), 256'(1));
  endtask

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #(10 * 400000);
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] pt1;
    logic [127:0] cap;
    int t, acc1, acc2, bad;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{128'h0,                                128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    init_sbox();
    set_key(vecs[0].key);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_rk_idx", 256'(rk_idx), 256'(10));
    check("rst_state", 256'(from_state(out_state)), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      set_key(vecs[i].key);
      run_block(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));
    end

    // Backpressure with in_valid pulses in DONE
    set_key(vecs[0].key);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = to_state(vecs[0].ct);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 60) begin @(negedge clk); t++; end
    cap = from_state(out_state);
    check("bp_pt", 256'(cap), 256'(vecs[0].pt));
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_state = to_state({$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      check("bp_vld", 256'(out_valid), 256'(1));
      check("bp_hold", 256'(from_state(out_state)), 256'(cap));
      check("bp_rdy", 256'(in_ready), 256'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_xfer_vld", 256'(out_valid), 256'(0));
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || !in_ready || rk_idx != 4'd10) bad++;
    end
    check("bp_not_stored", 256'(bad), 256'(0));

    // Back-to-back with in_valid held high
    set_key(vecs[1].key);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = to_state(vecs[1].ct);
    t = 0;
    acc1 = t;
    check("b2b_rdy1", 256'(in_ready), 256'(1));
    @(negedge clk); t++;
    in_state = to_state(vecs[2].ct);
    while (!out_valid && t < 60) begin @(negedge clk); t++; end
    check("b2b_pt1", 256'(from_state(out_state)), 256'(vecs[1].pt));
    @(negedge clk); t++;
    acc2 = t;
    check("b2b_rdy2", 256'(in_ready), 256'(1));
    check("b2b_gap", 256'(acc2 - acc1), 256'(LAT + 1));
    @(negedge clk); t++;
    in_valid = 1'b0;
    while (!out_valid && t < 120) begin @(negedge clk); t++; end
    check("b2b_pt2", 256'(from_state(out_state)), 256'(vecs[2].pt));
    @(negedge clk);

    // Reset in the middle of round processing
    set_key(vecs[0].key);
    in_valid = 1'b1;
    in_state = to_state(vecs[0].ct);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5 * RKREP) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_rk_idx", 256'(rk_idx), 256'(10));
    check("mrst_out_valid", 256'(out_valid), 256'(0));
    check("mrst_in_ready", 256'(in_ready), 256'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || !in_ready || rk_idx != 4'd10) bad++;
    end
    check("mrst_quiet", 256'(bad), 256'(0));
    run_block(vecs[0].ct, vecs[0].pt, "mrst_next");

    // Randomized blocks with gaps on both sides
    set_key({$urandom, $urandom, $urandom, $urandom});
    fork
      begin : drv
        logic [127:0] p;
        int w;
        for (int b = 0; b < NRAND; b++) begin
          p = {$urandom, $urandom, $urandom, $urandom};
          repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_state = to_state({$urandom, $urandom, $urandom, $urandom});
            @(negedge clk);
          end
          in_valid = 1'b1;
          in_state = to_state(encrypt(p));
          w = 0;
          while (!in_ready && w < 200) begin @(negedge clk); w++; end
          if (w >= 200) begin
            check("rand_accept_timeout", 256'(w), 256'(0));
            break;
          end
          exp_q.push_back(p);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : mon
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < NRAND && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected", 256'(from_state(out_state)), 256'(0));
            end else begin
              pt1 = exp_q.pop_front();
              check("rand", 256'(from_state(out_state)), 256'(pt1));
            end
            got++;
          end
        end
        if (got < NRAND) check("rand_count", 256'(got), 256'(NRAND));
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
